// File: rtl/song_sequencer.sv
// Multi-song, multi-voice song ROM sequencer: fetches entries, dispatches notes
// round-robin across voices and times advance entries in beat pulses.
module song_sequencer #(
  parameter int NOTE_W      = 6,
  parameter int DUR_W       = 6,
  parameter int SONG_ADDR_W = 7,
  parameter int SONG_SEL_W  = 2,
  parameter int NUM_VOICES  = 3,
  parameter int ENTRY_W     = 1 + NOTE_W + DUR_W + 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              play,
  input  logic [SONG_SEL_W-1:0]             song_sel,
  input  logic                              restart,
  input  logic                              beat,
  output logic [SONG_SEL_W+SONG_ADDR_W-1:0] rom_addr,
  input  logic [ENTRY_W-1:0]                rom_dout,
  output logic [NUM_VOICES-1:0]             voice_load,
  output logic [NOTE_W-1:0]                 voice_note,
  output logic [DUR_W-1:0]                  voice_dur,
  output logic                              playing,
  output logic                              song_done
);

  localparam int VP_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {
    IDLE, FETCH0, FETCH1, DECODE, WAIT, NEXT, DONE
  } state_t;

  state_t                 state;
  logic [SONG_SEL_W-1:0]  song;
  logic [SONG_ADDR_W-1:0] index;
  logic [VP_W-1:0]        vptr;
  logic [DUR_W-1:0]       count;

  logic                   entry_adv;
  logic [NOTE_W-1:0]      entry_note;
  logic [DUR_W-1:0]       entry_dur;
  logic [2:0]             unused_reserved;

  assign entry_adv       = rom_dout[ENTRY_W-1];
  assign entry_note      = rom_dout[ENTRY_W-2 -: NOTE_W];
  assign entry_dur       = rom_dout[ENTRY_W-2-NOTE_W -: DUR_W];
  assign unused_reserved = rom_dout[2:0];

  // Restart outranks every state; voice_load and song_done are single-cycle pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      song       <= '0;
      index      <= '0;
      vptr       <= '0;
      count      <= '0;
      rom_addr   <= '0;
      voice_load <= '0;
      voice_note <= '0;
      voice_dur  <= '0;
      playing    <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      voice_load <= '0;
      song_done  <= 1'b0;
      if (restart) begin
        song    <= song_sel;
        index   <= '0;
        vptr    <= '0;
        count   <= '0;
        playing <= 1'b1;
        state   <= FETCH0;
      end else begin
        case (state)
          IDLE: begin
            if (play) begin
              song    <= song_sel;
              index   <= '0;
              vptr    <= '0;
              playing <= 1'b1;
              state   <= FETCH0;
            end
          end
          FETCH0: begin
            if (play) begin
              rom_addr <= {song, index};
              state    <= FETCH1;
            end
          end
          FETCH1: state <= DECODE;
          DECODE: begin
            if (!entry_adv) begin
              voice_load <= NUM_VOICES'(1) << vptr;
              voice_note <= entry_note;
              voice_dur  <= entry_dur;
              if (vptr == VP_W'(NUM_VOICES - 1)) vptr <= '0;
              else vptr <= vptr + VP_W'(1);
              state <= NEXT;
            end else if (entry_dur == '0) begin
              state <= NEXT;
            end else begin
              count <= entry_dur;
              state <= WAIT;
            end
          end
          WAIT: begin
            if (beat && play) begin
              if (count == DUR_W'(1)) begin
                count <= '0;
                state <= NEXT;
              end else begin
                count <= count - DUR_W'(1);
              end
            end
          end
          // Reaching the last index ends the song instead of wrapping.
          NEXT: begin
            if (&index) begin
              state <= DONE;
            end else begin
              index <= index + SONG_ADDR_W'(1);
              state <= FETCH0;
            end
          end
          DONE: begin
            song_done <= 1'b1;
            playing   <= 1'b0;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Randomised self-checking bench for song_sequencer; a cycle-timeline model
// derived from the entry timing rules predicts every output per cycle.
module tb_song_sequencer;

  localparam int NW   = 6;
  localparam int DW   = 6;
  localparam int SA   = 3;
  localparam int SS   = 2;
  localparam int NV   = 3;
  localparam int EW   = 1 + NW + DW + 3;
  localparam int AW   = SS + SA;
  localparam int NENT = 1 << SA;
  localparam int NROM = 1 << AW;
  localparam int MAXC = 1024;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          play = 1'b0;
  logic [SS-1:0] song_sel = '0;
  logic          restart = 1'b0;
  logic          beat = 1'b0;
  logic [AW-1:0] rom_addr;
  logic [EW-1:0] rom_dout;
  logic [NV-1:0] voice_load;
  logic [NW-1:0] voice_note;
  logic [DW-1:0] voice_dur;
  logic          playing;
  logic          song_done;

  int vectors = 0;
  int miscompares = 0;

  logic [EW-1:0] rom   [NROM];
  bit            m_adv [NROM];
  int            m_note[NROM];
  int            m_dur [NROM];

  bit            beat_pat[MAXC];
  bit            play_pat[MAXC];
  bit            e_issue[MAXC];
  int            e_issue_addr[MAXC];
  int            e_load[MAXC];
  int            e_note[MAXC];
  int            e_dur[MAXC];

  song_sequencer #(
    .NOTE_W(NW), .DUR_W(DW), .SONG_ADDR_W(SA), .SONG_SEL_W(SS), .NUM_VOICES(NV)
  ) dut (
    .clk(clk), .reset(reset), .play(play), .song_sel(song_sel),
    .restart(restart), .beat(beat), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .voice_load(voice_load), .voice_note(voice_note), .voice_dur(voice_dur),
    .playing(playing), .song_done(song_done)
  );

  always #5 clk = ~clk;

  // Synchronous ROM with one cycle of read latency.
  always @(posedge clk) rom_dout <= rom[rom_addr];

  task automatic set_entry(input int song, input int idx, input bit a, input int n, input int d);
    int k;
    logic [2:0] rsv;
    k = song * NENT + idx;
    rsv = 3'($urandom);
    m_adv[k] = a;
    m_note[k] = n;
    m_dur[k] = d;
    rom[k] = {a, NW'(n), DW'(d), rsv};
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    play = 1'b0;
    beat = 1'b0;
    restart = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Builds a per-cycle expectation from the entry timing rules, then replays
  // the play/beat patterns and compares every output on every cycle.
  task automatic run_song(input int song, input string tag);
    int c, f, nx, cnt, vp, start, firstp, done;
    int exp_addr, exp_note, exp_dur, k;
    for (int i = 0; i < MAXC; i++) begin
      e_issue[i] = 0;
      e_load[i] = 0;
    end
    c = 0;
    while (c < MAXC - 64 && !play_pat[c]) c++;
    firstp = c;
    start = c + 1;
    f = start;
    vp = 0;
    nx = 0;
    for (int idx = 0; idx < NENT; idx++) begin
      while (f < MAXC - 64 && !play_pat[f]) f++;
      k = song * NENT + idx;
      e_issue[f + 1] = 1;
      e_issue_addr[f + 1] = k;
      if (!m_adv[k]) begin
        e_load[f + 3] = 1 << vp;
        e_note[f + 3] = m_note[k];
        e_dur[f + 3] = m_dur[k];
        vp = (vp + 1) % NV;
        nx = f + 3;
      end else if (m_dur[k] == 0) begin
        nx = f + 3;
      end else begin
        cnt = m_dur[k];
        c = f + 3;
        while (c < MAXC - 64) begin
          if (beat_pat[c] && play_pat[c]) begin
            cnt--;
            if (cnt == 0) break;
          end
          c++;
        end
        nx = c + 1;
      end
      f = nx + 1;
    end
    done = nx + 2;
    if (done > MAXC - 16) begin
      miscompares++;
      $display("[TB] FAIL %s model_length: got %0d cycles, required below %0d", tag, done, MAXC - 16);
      return;
    end
    for (int i = done; i < MAXC; i++) play_pat[i] = 0;

    exp_addr = 0;
    exp_note = 0;
    exp_dur = 0;
    for (int n = 0; n <= done + 8; n++) begin
      @(negedge clk);
      if (e_issue[n]) exp_addr = e_issue_addr[n];
      if (e_load[n] != 0) begin
        exp_note = e_note[n];
        exp_dur = e_dur[n];
      end
      vectors++;
      if (rom_addr !== AW'(exp_addr)) begin
        miscompares++;
        $display("[TB] FAIL %s rom_addr cycle %0d: got %h, required %h", tag, n, rom_addr, AW'(exp_addr));
      end
      vectors++;
      if (voice_load !== NV'(e_load[n])) begin
        miscompares++;
        $display("[TB] FAIL %s voice_load cycle %0d: got %b, required %b", tag, n, voice_load, NV'(e_load[n]));
      end
      vectors++;
      if (voice_note !== NW'(exp_note) || voice_dur !== DW'(exp_dur)) begin
        miscompares++;
        $display("[TB] FAIL %s note_dur cycle %0d: got %0d/%0d, required %0d/%0d",
                 tag, n, voice_note, voice_dur, exp_note, exp_dur);
      end
      vectors++;
      if (playing !== (n >= start && n < done)) begin
        miscompares++;
        $display("[TB] FAIL %s playing cycle %0d: got %b, required %b", tag, n, playing, (n >= start && n < done));
      end
      vectors++;
      if (song_done !== (n == done)) begin
        miscompares++;
        $display("[TB] FAIL %s song_done cycle %0d: got %b, required %b", tag, n, song_done, (n == done));
      end
      play = play_pat[n];
      beat = beat_pat[n];
      song_sel = (n <= firstp) ? SS'(song) : SS'($urandom);
    end
    play = 1'b0;
    beat = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #3;
    vectors++;
    if ({rom_addr, voice_load, voice_note, voice_dur, playing, song_done} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got addr=%h load=%b note=%0d dur=%0d playing=%b done=%b, required all zero",
               rom_addr, voice_load, voice_note, voice_dur, playing, song_done);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (playing !== 1'b0 || rom_addr !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_idle: got playing=%b addr=%h, required 0/00", playing, rom_addr);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    set_entry(1, 0, 1'b0, 17, 9);
    set_entry(1, 1, 1'b1, 0, 20);
    for (int n = 0; n <= 12; n++) begin
      @(negedge clk);
      play = 1'b1;
      song_sel = 2'd1;
      beat = 1'b0;
    end
    vectors++;
    if (voice_note !== NW'(17) || rom_addr !== AW'(NENT + 1) || playing !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL pre_reset_wait: got note=%0d addr=%h playing=%b, required 17/%h/1",
               voice_note, rom_addr, playing, AW'(NENT + 1));
    end
    reset = 1'b1;
    #1;
    vectors++;
    if ({rom_addr, voice_load, voice_note, voice_dur, playing, song_done} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_wait: got addr=%h load=%b note=%0d dur=%0d playing=%b, required all zero",
               rom_addr, voice_load, voice_note, voice_dur, playing);
    end
    @(negedge clk);
    play = 1'b0;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (playing !== 1'b0 || rom_addr !== '0 || voice_load !== '0) begin
      miscompares++;
      $display("[TB] FAIL idle_after_reset: got playing=%b addr=%h load=%b, required 0/00/000",
               playing, rom_addr, voice_load);
    end
  endtask

  task automatic test_chord();
    do_reset();
    set_entry(0, 0, 1'b0, 28, 48);
    set_entry(0, 1, 1'b0, 40, 48);
    set_entry(0, 2, 1'b1, 0, 3);
    for (int i = 3; i < NENT; i++) set_entry(0, i, 1'b1, 0, 0);
    for (int i = 0; i < MAXC; i++) begin
      play_pat[i] = 1;
      beat_pat[i] = (i % 3 == 2);
    end
    run_song(0, "chord");
  endtask

  task automatic test_adv_zero();
    do_reset();
    for (int i = 0; i < NENT; i++) set_entry(2, i, 1'b0, $urandom_range(1, 63), $urandom_range(0, 63));
    set_entry(2, 5, 1'b1, 0, 0);
    for (int i = 0; i < MAXC; i++) begin
      play_pat[i] = 1;
      beat_pat[i] = 0;
    end
    run_song(2, "adv_zero");
  endtask

  task automatic test_pause();
    do_reset();
    set_entry(3, 0, 1'b1, 0, 4);
    for (int i = 1; i < NENT; i++) set_entry(3, i, 1'b1, 0, 0);
    for (int i = 0; i < MAXC; i++) begin
      play_pat[i] = !(i >= 10 && i <= 25);
      beat_pat[i] = 0;
    end
    beat_pat[3] = 1;
    beat_pat[6] = 1;
    beat_pat[8] = 1;
    for (int i = 12; i <= 20; i += 2) beat_pat[i] = 1;
    beat_pat[28] = 1;
    beat_pat[30] = 1;
    run_song(3, "pause");
  endtask

  task automatic test_song_end();
    do_reset();
    for (int i = 0; i < NENT; i++) set_entry(1, i, 1'b1, 0, 1);
    for (int i = 0; i < MAXC; i++) begin
      play_pat[i] = 1;
      beat_pat[i] = (i % 10 == 9);
    end
    run_song(1, "song_end");
  endtask

  task automatic test_random(input int iter);
    int song;
    do_reset();
    song = $urandom_range(0, 3);
    for (int i = 0; i < NENT; i++) begin
      if ($urandom_range(0, 1) == 1) set_entry(song, i, 1'b1, $urandom_range(0, 63), $urandom_range(0, 3));
      else set_entry(song, i, 1'b0, $urandom_range(0, 63), $urandom_range(0, 63));
    end
    for (int i = 0; i < MAXC; i++) begin
      play_pat[i] = ($urandom_range(0, 7) != 0);
      beat_pat[i] = ($urandom_range(0, 2) == 0);
    end
    run_song(song, $sformatf("random%0d", iter));
  endtask

  task automatic test_restart();
    int a;
    int n1;
    bit found;
    do_reset();
    for (int i = 0; i < NENT; i++) set_entry(0, i, 1'b0, $urandom_range(1, 63), $urandom_range(1, 63));
    n1 = $urandom_range(1, 63);
    set_entry(1, 0, 1'b0, n1, 33);
    for (int i = 1; i < NENT; i++) set_entry(1, i, 1'b1, 0, 5);
    found = 0;
    for (a = 0; a < 100; a++) begin
      @(negedge clk);
      if (rom_addr === AW'(5)) begin
        found = 1;
        break;
      end
      play = 1'b1;
      song_sel = 2'd0;
      beat = 1'b0;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL restart_reach_index5: got addr=%h after 100 cycles, required 05", rom_addr);
      return;
    end
    @(negedge clk);
    restart = 1'b1;
    song_sel = 2'd1;
    @(negedge clk);
    restart = 1'b0;
    song_sel = 2'd2;
    vectors++;
    if (voice_load !== '0 || playing !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL restart_suppress: got load=%b playing=%b, required 000/1", voice_load, playing);
    end
    @(negedge clk);
    vectors++;
    if (rom_addr !== AW'(NENT)) begin
      miscompares++;
      $display("[TB] FAIL restart_addr: got %h, required %h", rom_addr, AW'(NENT));
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (voice_load !== NV'(1) || voice_note !== NW'(n1) || voice_dur !== DW'(33)) begin
      miscompares++;
      $display("[TB] FAIL restart_voice0: got load=%b note=%0d dur=%0d, required 001/%0d/33",
               voice_load, voice_note, voice_dur, n1);
    end
    play = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < NROM; i++) set_entry(i / NENT, i % NENT, 1'b1, 0, 0);
    test_reset();
    test_reset_mid_wait();
    test_chord();
    test_adv_zero();
    test_pause();
    test_song_end();
    test_restart();
    for (int i = 0; i < 6; i++) test_random(i);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Parametrised successor to the single-song, single-voice song ROM.
- Walks a multi-song synchronous song ROM and decodes each entry.
- Dispatches note entries round-robin across NUM_VOICES note players, so chords play on separate voices.
- Times advance entries by counting beat pulses; provides play/pause, song select, restart and end-of-song signalling.

Parameters:
NOTE_W, 6, note field width (note 0 = rest/silence)
DUR_W, 6, duration field width (beats)
SONG_ADDR_W, 7, log2 entries per song
SONG_SEL_W, 2, log2 number of songs
NUM_VOICES, 3, voice outputs (>=1)
ENTRY_W, 1+NOTE_W+DUR_W+3, ROM word width; entry = {adv, note, dur, 3 reserved bits}

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
play  in  1  level; 1 = run, 0 = pause
song_sel  in  SONG_SEL_W  song to start; latched on start/restart
restart  in  1  one-cycle pulse: restart latched song_sel from entry 0
beat  in  1  one-cycle beat tick
rom_addr  out  SONG_SEL_W+SONG_ADDR_W  registered {song, index} to sync ROM (1-cycle read latency)
rom_dout  in  ENTRY_W  ROM data
voice_load  out  NUM_VOICES  one-hot load pulse
voice_note  out  NOTE_W  note for loaded voice
voice_dur  out  DUR_W  duration for loaded voice
playing  out  1  high from song start until end/reset
song_done  out  1  one-cycle pulse at end of song

Behaviour:
- Reset (async, any state): state IDLE; rom_addr=0; voice_load=0; voice_note=0; voice_dur=0; playing=0; song_done=0; index=0; voice pointer=0; beat counter=0.
- States:
  - IDLE → FETCH0 when play=1: latch song_sel, index=0, voice pointer=0, playing=1.
  - FETCH0: rom_addr <= {song, index} → FETCH1. FETCH0 is entered only if play=1; otherwise holds.
  - FETCH1: wait for ROM → DECODE.
  - DECODE: sample rom_dout.
    - adv=0: voice_load one-hot at voice pointer for exactly this cycle; voice_note/voice_dur = fields (held until next load); pointer = (pointer+1) mod NUM_VOICES; → NEXT.
    - adv=1, dur=0: → NEXT, no wait.
    - adv=1, dur>0: load counter=dur → WAIT.
  - WAIT: on beat & play, counter-1; when counter reaches 0 → NEXT. beat ignored while play=0 (counter frozen).
  - NEXT: if index = all-ones → DONE; else index+1 → FETCH0.
  - DONE: song_done=1 for one cycle, playing=0 → IDLE.
- Latency: note entry = 4 cycles FETCH0→FETCH0 (FETCH0, FETCH1, DECODE, NEXT); advance entry dur=d = 4 cycles + time to d counted beats.
- Pause: play=0 never aborts an in-flight fetch; the entry completes and dispatches. Sequencer then halts in FETCH0 or WAIT.
- restart pulse (any non-reset state, highest priority): latch song_sel, index=0, pointer=0, counter=0, voice_load=0 that cycle, playing=1, next state FETCH0.
  - restart in DECODE suppresses that dispatch.
  - restart in DONE suppresses song_done.
- Beat coincident with entry into WAIT is not counted; only beats seen while in WAIT count.
- Reserved bits ignored. Field extraction: adv=rom_dout[ENTRY_W-1], note next NOTE_W bits, dur next DUR_W bits.
- No arithmetic overflow: index wrap is the end condition, never a silent wrap.

Test Plan:
1. Reset asserted mid-WAIT (counter=20) → same cycle all outputs 0, playing=0; after release stays IDLE with play=0.
2. NUM_VOICES=2, song 0 entries {0,28,48},{0,40,48},{1,0,3}, play=1 → voice_load=01 note 28 dur 48; 4 cycles later voice_load=10 note 40 dur 48; rom_addr then holds index 2 until 3 beats counted, then index 3 issued.
3. Entry {1,0,0} at index 5 → index 6 fetched 4 cycles after index 5 FETCH0, with no beat applied.
4. WAIT with dur=4: 2 beats, play=0, 5 beats, play=1, 2 beats → exits WAIT only after the final 2nd beat post-resume (4 counted total).
5. SONG_ADDR_W=2, all entries {1,0,1}, beat each 10 cycles → exactly one song_done pulse after 4th entry; playing falls same cycle; no further rom_addr change.
6. Mid-song (song 0, index 9) pulse restart with song_sel=1 → next FETCH0 drives rom_addr={1,0}; next note loads voice 0.
